// File: rtl/cla_add_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla_pkg : shared constants and FSM state type for cla_add_arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int SLICE_W = 4;
  localparam int ID_W    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_add_arbiter_cla4_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla4_slice : 4-bit combinational carry-lookahead adder slice.     Rev 1.0
// ---------------------------------------------------------------------------
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum of products of g/p and cin, no ripple path.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s = w_p ^ w_c;

endmodule : cla4_slice
`default_nettype wire

// File: rtl/cla_add_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla_add_arbiter : two-client round-robin front end that runs WIDTH-bit
// additions through one shared 4-bit CLA slice, one slice per cycle. Rev 1.0
// ---------------------------------------------------------------------------
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  output logic             busy
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH:0]    sum_q, sum_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_last_q, rr_last_d;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic              idle;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic              slice_cout;

  assign idle    = (state_q == IDLE);
  assign gnt_any = req0_valid | req1_valid;
  // On contention the requester that did not win last time goes first.
  assign gnt_id  = (req0_valid && req1_valid) ? ~rr_last_q
                 : (req1_valid ? ID_W'(1) : ID_W'(0));

  assign req0_ready = rst_n & idle & gnt_any & (gnt_id == ID_W'(0));
  assign req1_ready = rst_n & idle & gnt_any & (gnt_id == ID_W'(1));

  assign slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d       = (gnt_id == ID_W'(1)) ? req1_a : req0_a;
          b_d       = (gnt_id == ID_W'(1)) ? req1_b : req0_b;
          id_d      = gnt_id;
          rr_last_d = gnt_id;
          idx_d     = '0;
          carry_d   = 1'b0;
          sum_d     = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
          sum_d[WIDTH] = slice_cout;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rr_last_q <= ID_W'(1);
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign busy      = ~idle;

endmodule : cla_add_arbiter
`default_nettype wire

// File: doc/cla_add_arbiter.md
Name: cla_add_arbiter

Overview:
- Shares one 4-bit carry-lookahead slice between two requesters.
- Sequences WIDTH-bit additions slice-by-slice over WIDTH/4 cycles, chaining the carry through a register.
- Round-robin arbitration on requests; single response port tagged with requester id.
- Sits between client logic and the CLA datapath; replaces per-client wide adders where area matters.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NUM_SLICES, WIDTH/4, derived count of slices and ADD cycles; not overridden.

Ports:
- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- req0_valid  in  1  Requester 0 has operands.
- req0_ready  out  1  Requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  Requester 0 operand A.
- req0_b  in  WIDTH  Requester 0 operand B.
- req1_valid  in  1  Requester 1 has operands.
- req1_ready  out  1  Requester 1 operands accepted this cycle.
- req1_a  in  WIDTH  Requester 1 operand A.
- req1_b  in  WIDTH  Requester 1 operand B.
- rsp_valid  out  1  Result available.
- rsp_ready  in  1  Consumer takes result.
- rsp_id  out  1  Requester that owns the result.
- rsp_sum  out  WIDTH+1  A+B; MSB is the final carry.
- busy  out  1  High in ADD or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, slice index=0, carry=0, sum_reg=0, rr_last=1.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0.
  - req0_ready and req1_ready are gated to 0 while rst_n is low.
- States: IDLE, ADD, DONE.
- IDLE:
  - Grant when any reqN_valid is high.
  - Only one valid: grant it.
  - Both valid: grant the id != rr_last.
  - reqN_ready is combinational and high only for the granted requester in IDLE; a handshake is valid&ready.
  - On handshake: latch A, B; id_reg<=granted; rr_last<=granted; idx<=0; carry<=0; sum_reg<=0; go to ADD.
- ADD: each cycle the slice computes a[idx*4+:4] + b[idx*4+:4] + carry.
  - sum_reg[idx*4+:4]<=slice sum; carry<=cout; idx<=idx+1.
  - When idx==NUM_SLICES-1: sum_reg[WIDTH]<=cout and go to DONE.
  - Exactly NUM_SLICES cycles are spent in ADD.
- DONE:
  - rsp_valid=1; rsp_sum=sum_reg; rsp_id=id_reg.
  - All three outputs are held stable until rsp_ready.
  - On rsp_valid&rsp_ready go to IDLE; rsp_valid drops next cycle.
- Timing:
  - Latency: handshake in cycle c gives rsp_valid high from cycle c+NUM_SLICES+1 (c+5 for WIDTH=16).
  - Throughput: one op per NUM_SLICES+2 cycles with rsp_ready tied high.
- Arithmetic:
  - Unsigned; no overflow is possible because the WIDTH+1 result holds the full sum.
  - idx has width $clog2(NUM_SLICES), minimum 1 bit.
- Boundaries:
  - Requests arriving during ADD/DONE see ready=0 and must hold; they are never dropped.
  - reqN_valid falling before the handshake means no grant and no state change.
  - Reset mid-ADD or mid-DONE discards the operation; no response is ever produced for it.
  - rsp_ready high outside DONE is ignored.
- busy = (state != IDLE).

Decomposition:
- Package cla_pkg:
  - SLICE_W=4.
  - State encoding constants: IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - ID_W=1.
- Sub-module cla4_slice, purely combinational:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Internal per-bit generate/propagate with lookahead carries.
  - Instantiated once.
- Arbitration and FSM live in the top module.

Test Plan:
- req0 only, A=0x1234, B=0x4321, rsp_ready=1 -> rsp_valid exactly 5 cycles after handshake, rsp_sum=0x05555, rsp_id=0, busy high for 5 cycles.
- req1 only, A=0xFFFF, B=0x0001 -> carry ripples through all 4 slices, rsp_sum=0x10000, rsp_id=1.
- Both valid in the first cycle after reset: req0 A=0x00FF B=0x0001, req1 A=0x8000 B=0x8000 -> req0 granted first (rsp_sum=0x00100, id 0), then req1 (rsp_sum=0x10000, id 1); req1_ready stays 0 until IDLE returns.
- Backpressure: rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable; both readies stay 0 even with req valid; result taken on the 4th cycle.
- Reset mid-ADD: pulse rst_n low in the 2nd ADD cycle of 0x7777+0x1111 -> all outputs 0 immediately, no response; next op 0x0001+0x0002 gives 0x00003, id 0.
- Fairness: both requesters held valid for 4 ops -> rsp_id sequence 0,1,0,1, with each sum correct.
